// File: rtl/vga_pkg.sv
// VGA timing constants, pixel flag bundle and range helper
// shared by the frame reader and its timing generator.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = 800;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = 525;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int RGB_W  = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic vis;
    logic win;
    logic hsync;
    logic vsync;
  } pix_flags_t;

  // lo <= c < lo+len, evaluated in 32-bit space
  function automatic logic in_span(
    input logic [9:0] c,
    input int         lo,
    input int         len
  );
    int ci;
    ci = int'(c);
    return (ci >= lo) && (ci < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel enable, h/v counters and raw visible/sync flags.
// Ports: clk50m, rst in; pix_en, hcnt, vcnt, visible, hsync, vsync out.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HVIS  = H_VIS,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VVIS  = V_VIS,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP
) (
  input  logic       clk50m,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       visible,
  output logic       hsync,
  output logic       vsync
);

  localparam int HTOT = HVIS + HFP + HSYNC + HBP;
  localparam int VTOT = VVIS + VFP + VSYNC + VBP;

  localparam logic [9:0] H_LAST = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST = 10'(VTOT - 1);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) pix_en <= 1'b0;
    else     pix_en <= ~pix_en;
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign visible = in_span(hcnt, 0, HVIS)
                 && in_span(vcnt, 0, VVIS);
  assign hsync   = in_span(hcnt, HVIS + HFP, HSYNC);
  assign vsync   = in_span(vcnt, VVIS + VFP, VSYNC);

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a 128x128 framebuffer at 2x into a 640x480 VGA raster.
// Ports: clk50m, rst, vdata in; vaddr, vgar/g/b, hs, vs out.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int   IMG_X0 = 192,
  parameter int   IMG_Y0 = 112,
  parameter rgb_t BG_RGB = 12'h000,
  parameter int   HVIS   = H_VIS,
  parameter int   HFP    = H_FP,
  parameter int   HSYNC  = H_SYNC,
  parameter int   HBP    = H_BP,
  parameter int   VVIS   = V_VIS,
  parameter int   VFP    = V_FP,
  parameter int   VSYNC  = V_SYNC,
  parameter int   VBP    = V_BP
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic [RGB_W-1:0] vdata,
  output logic [15:0]      vaddr,
  output logic [3:0]       vgar,
  output logic [3:0]       vgag,
  output logic [3:0]       vgab,
  output logic             hs,
  output logic             vs
);

  localparam int WIN_W = 2 * IMG_W;
  localparam int WIN_H = 2 * IMG_H;

  logic       pix_en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       visible;
  logic       hsync;
  logic       vsync;

  vga_timing #(
    .HVIS  (HVIS),
    .HFP   (HFP),
    .HSYNC (HSYNC),
    .HBP   (HBP),
    .VVIS  (VVIS),
    .VFP   (VFP),
    .VSYNC (VSYNC),
    .VBP   (VBP)
  ) u_timing (
    .clk50m  (clk50m),
    .rst     (rst),
    .pix_en  (pix_en),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .visible (visible),
    .hsync   (hsync),
    .vsync   (vsync)
  );

  logic       in_win;
  logic [6:0] xs;
  logic [6:0] ys;
  pix_flags_t f0;
  pix_flags_t f1;
  rgb_t       rgb_nxt;
  rgb_t       rgb_q;

  assign in_win = in_span(hcnt, IMG_X0, WIN_W)
                && in_span(vcnt, IMG_Y0, WIN_H);

  // window offset halved: each image pixel covers 2x2
  assign xs = 7'((hcnt - 10'(IMG_X0)) >> 1);
  assign ys = 7'((vcnt - 10'(IMG_Y0)) >> 1);

  assign f0 = '{
    vis:   visible,
    win:   in_win,
    hsync: hsync,
    vsync: vsync
  };

  // address stage; vaddr holds outside the window
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      vaddr <= '0;
      f1    <= '0;
    end else if (pix_en) begin
      f1 <= f0;
      if (in_win) vaddr <= {2'b00, ys, xs};
    end
  end

  always_comb begin
    rgb_nxt = '0;
    unique case (1'b1)
      (f1.vis &&  f1.win): rgb_nxt = vdata;
      (f1.vis && !f1.win): rgb_nxt = BG_RGB;
      default:             rgb_nxt = '0;
    endcase
  end

  // colour stage, aligned with returned vdata
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      hs    <= 1'b1;
      vs    <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= rgb_nxt;
      hs    <= ~f1.hsync;
      vs    <= ~f1.vsync;
    end
  end

  assign vgar = rgb_q[11:8];
  assign vgag = rgb_q[7:4];
  assign vgab = rgb_q[3:0];

endmodule
